// File: rtl/if_stage_ctl.sv
// Instruction-fetch stage controller: PC sequencing, redirect bubbles, stall hold.
// Optional perf counters enabled by IF_STAGE_PERF_CNT_EN.
module if_stage_ctl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic [1:0]  fsm_state
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        HOLD  = 2'b01,
        FLUSH = 2'b10
    } state_e;

    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam state_e     BR_NEXT      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_e      state_q, state_d, eff_state;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        // HOLD resumes whichever state it interrupted, acting this same cycle
        eff_state = state_q;
        if (state_q == HOLD) begin
            eff_state = (cnt_q != 2'd0) ? FLUSH : RUN;
        end
        if (branch_taken) begin
            pc_d    = branch_target & 32'hFFFF_FFFC;
            instr_d = NOP_INSTR;
            ipc_d   = pc_q;
            valid_d = 1'b0;
            cnt_d   = FLUSH_RELOAD;
            state_d = BR_NEXT;
        end else if (stall) begin
            state_d = HOLD;
        end else if (eff_state == FLUSH) begin
            pc_d    = pc_q + 32'd4;
            instr_d = NOP_INSTR;
            ipc_d   = pc_q;
            valid_d = 1'b0;
            cnt_d   = cnt_q - 2'd1;
            state_d = (cnt_q == 2'd1) ? RUN : FLUSH;
        end else begin
            pc_d    = pc_q + 32'd4;
            instr_d = instr_in;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ipc_q   <= RESET_PC;
            valid_q <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ipc_q;
    assign if_id_valid = valid_q;
    assign fsm_state   = state_q;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (branch_taken && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
            if (stall && !branch_taken && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_ctl.sv
// Bench for if_stage_ctl: three instances with different RESET_PC/FLUSH_CYCLES,
// vector table, directed corner sequences and random stimulus vs. a reference model.
module tb_if_stage_ctl;

    localparam int          N   = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] IA  = 32'h0010_0093;
    localparam logic [31:0] IB  = 32'h1234_5678;

    function automatic logic [31:0] rp_f(input int k);
        case (k)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFF8;
            default: return 32'h0000_1000;
        endcase
    endfunction

    function automatic int fc_f(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = 32'd0;
    logic [31:0] instr = 32'd0;

    logic [31:0] pc_o [N];
    logic [31:0] ii_o [N];
    logic [31:0] ip_o [N];
    logic        v_o  [N];
    logic [1:0]  st_o [N];
`ifdef IF_STAGE_PERF_CNT_EN
    logic [15:0] sc_o [N];
    logic [15:0] fe_o [N];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        if_stage_ctl #(
            .RESET_PC    (rp_f(g)),
            .NOP_INSTR   (NOP),
            .FLUSH_CYCLES(fc_f(g))
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .stall        (stall),
            .branch_taken (br),
            .branch_target(tgt),
            .instr_in     (instr),
            .pc           (pc_o[g]),
            .if_id_instr  (ii_o[g]),
            .if_id_pc     (ip_o[g]),
            .if_id_valid  (v_o[g]),
            .fsm_state    (st_o[g])
`ifdef IF_STAGE_PERF_CNT_EN
            ,
            .stall_cycles (sc_o[g]),
            .flush_events (fe_o[g])
`endif
        );
    end

    // Reference model: remaining bubbles after a redirect plus a "frozen" flag.
    logic [31:0] m_pc  [N];
    logic [31:0] m_ipc [N];
    logic [31:0] m_ins [N];
    bit          m_v   [N];
    int          m_bub [N];
    bit          m_held[N];
    int          m_sc  [N];
    int          m_fe  [N];

    int cmp = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < N; k++) begin
            m_pc[k]   = rp_f(k);
            m_ipc[k]  = rp_f(k);
            m_ins[k]  = NOP;
            m_v[k]    = 1'b0;
            m_bub[k]  = 0;
            m_held[k] = 1'b0;
            m_sc[k]   = 0;
            m_fe[k]   = 0;
        end
    endtask

    task automatic m_step(input bit s, input bit b, input logic [31:0] t,
                          input logic [31:0] i);
        for (int k = 0; k < N; k++) begin
            if (b) begin
                m_ipc[k]  = m_pc[k];
                m_pc[k]   = {t[31:2], 2'b00};
                m_ins[k]  = NOP;
                m_v[k]    = 1'b0;
                m_bub[k]  = fc_f(k) - 1;
                m_held[k] = 1'b0;
                if (m_fe[k] < 65535) m_fe[k]++;
            end else if (s) begin
                m_held[k] = 1'b1;
                if (m_sc[k] < 65535) m_sc[k]++;
            end else begin
                m_held[k] = 1'b0;
                m_ipc[k]  = m_pc[k];
                m_pc[k]   = m_pc[k] + 32'd4;
                if (m_bub[k] > 0) begin
                    m_ins[k] = NOP;
                    m_v[k]   = 1'b0;
                    m_bub[k]--;
                end else begin
                    m_ins[k] = i;
                    m_v[k]   = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [31:0] m_state(input int k);
        if (m_held[k]) return 32'd1;
        if (m_bub[k] > 0) return 32'd2;
        return 32'd0;
    endfunction

    task automatic chk_all(input string tag);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s.d%0d.pc", tag, k), pc_o[k], m_pc[k]);
            chk($sformatf("%s.d%0d.ipc", tag, k), ip_o[k], m_ipc[k]);
            chk($sformatf("%s.d%0d.ins", tag, k), ii_o[k], m_ins[k]);
            chk($sformatf("%s.d%0d.v", tag, k), 32'(v_o[k]), 32'(m_v[k]));
            chk($sformatf("%s.d%0d.st", tag, k), 32'(st_o[k]), m_state(k));
`ifdef IF_STAGE_PERF_CNT_EN
            chk($sformatf("%s.d%0d.sc", tag, k), 32'(sc_o[k]), 32'(m_sc[k]));
            chk($sformatf("%s.d%0d.fe", tag, k), 32'(fe_o[k]), 32'(m_fe[k]));
`endif
        end
    endtask

    task automatic cyc(input bit s, input bit b, input logic [31:0] t,
                       input logic [31:0] i);
        stall = s;
        br    = b;
        tgt   = t;
        instr = i;
        m_step(s, b, t, i);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk_all("rstp");
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          s;
        bit          b;
        logic [31:0] t;
        logic [31:0] i;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] ins;
        bit          v;
        logic [1:0]  st;
    } vec_t;

    vec_t tv[13];

    initial begin
        tv[0]  = '{0, 0, 0,       IA, 32'h4,   32'h0,   IA,  1, 0};
        tv[1]  = '{0, 0, 0,       IA, 32'h8,   32'h4,   IA,  1, 0};
        tv[2]  = '{1, 0, 0,       IA, 32'h8,   32'h4,   IA,  1, 1};
        tv[3]  = '{1, 0, 0,       IA, 32'h8,   32'h4,   IA,  1, 1};
        tv[4]  = '{1, 0, 0,       IA, 32'h8,   32'h4,   IA,  1, 1};
        tv[5]  = '{0, 0, 0,       IA, 32'hC,   32'h8,   IA,  1, 0};
        tv[6]  = '{1, 1, 32'h203, IA, 32'h200, 32'hC,   NOP, 0, 0};
        tv[7]  = '{0, 0, 0,       IA, 32'h204, 32'h200, IA,  1, 0};
        tv[8]  = '{0, 1, 32'h40,  IA, 32'h40,  32'h204, NOP, 0, 0};
        tv[9]  = '{0, 1, 32'h80,  IA, 32'h80,  32'h40,  NOP, 0, 0};
        tv[10] = '{0, 0, 0,       IB, 32'h84,  32'h80,  IB,  1, 0};
        tv[11] = '{1, 0, 0,       IA, 32'h84,  32'h80,  IB,  1, 1};
        tv[12] = '{0, 0, 0,       IA, 32'h88,  32'h84,  IA,  1, 0};

        m_reset();
        #12;
        chk("rst.pc", pc_o[0], 32'h0);
        chk("rst.ipc", ip_o[0], 32'h0);
        chk("rst.ins", ii_o[0], NOP);
        chk("rst.v", 32'(v_o[0]), 32'h0);
        chk("rst.st", 32'(st_o[0]), 32'h0);
        chk_all("rst");
        rst_n = 1'b1;

        for (int n = 0; n < 13; n++) begin
            cyc(tv[n].s, tv[n].b, tv[n].t, tv[n].i);
            chk($sformatf("tv%0d.pc", n), pc_o[0], tv[n].pc);
            chk($sformatf("tv%0d.ipc", n), ip_o[0], tv[n].ipc);
            chk($sformatf("tv%0d.ins", n), ii_o[0], tv[n].ins);
            chk($sformatf("tv%0d.v", n), 32'(v_o[0]), 32'(tv[n].v));
            chk($sformatf("tv%0d.st", n), 32'(st_o[0]), 32'(tv[n].st));
            chk_all($sformatf("tv%0d", n));
        end
`ifdef IF_STAGE_PERF_CNT_EN
        chk("tv.sc", 32'(sc_o[0]), 32'd4);
        chk("tv.fe", 32'(fe_o[0]), 32'd3);
`endif

        // PC wrap and two-bubble redirect on the FLUSH_CYCLES=2 instance
        pulse_reset();
        cyc(0, 0, 0, IA);
        chk("wrap0", pc_o[1], 32'hFFFF_FFFC);
        cyc(0, 0, 0, IA);
        chk("wrap1", pc_o[1], 32'h0000_0000);
        cyc(0, 0, 0, IA);
        chk("wrap2", pc_o[1], 32'h0000_0004);
        cyc(0, 1, 32'h103, IA);
        chk("fl2.pc", pc_o[1], 32'h100);
        chk("fl2.v0", 32'(v_o[1]), 32'h0);
        chk("fl2.st", 32'(st_o[1]), 32'h2);
        cyc(0, 0, 0, IA);
        chk("fl2.pc1", pc_o[1], 32'h104);
        chk("fl2.v1", 32'(v_o[1]), 32'h0);
        chk("fl2.ins1", ii_o[1], NOP);
        cyc(0, 0, 0, IA);
        chk("fl2.v2", 32'(v_o[1]), 32'h1);
        chk("fl2.ipc2", ip_o[1], 32'h104);
        chk_all("fl2");

        // Stall in the middle of a 3-cycle flush, then resume
        cyc(0, 1, 32'h500, IA);
        cyc(1, 0, 0, IA);
        chk("fl3.hold", 32'(st_o[2]), 32'h1);
        cyc(0, 0, 0, IB);
        chk("fl3.resume", 32'(st_o[2]), 32'h2);
        chk_all("fl3");
        cyc(0, 0, 0, IB);
        cyc(0, 0, 0, IB);
        chk_all("fl3e");

        // Reset mid-FLUSH, then mid-HOLD
        cyc(0, 1, 32'h700, IA);
        chk("rf.st", 32'(st_o[1]), 32'h2);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("rf.pc", pc_o[1], 32'hFFFF_FFF8);
        chk("rf.v", 32'(v_o[1]), 32'h0);
        chk("rf.stz", 32'(st_o[1]), 32'h0);
        #2;
        rst_n = 1'b1;
        cyc(0, 0, 0, IA);
        chk("rf.run.pc", pc_o[1], 32'hFFFF_FFFC);
        chk("rf.run.v", 32'(v_o[1]), 32'h1);
        chk_all("rf");
        cyc(1, 0, 0, IA);
        pulse_reset();
        cyc(0, 0, 0, IB);
        chk_all("rh");

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) pulse_reset();
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                $urandom, $urandom);
            chk_all($sformatf("rnd%0d", n));
        end

`ifdef IF_STAGE_PERF_CNT_EN
        pulse_reset();
        for (int n = 0; n < 70000; n++) cyc(1, 0, 0, IA);
        chk("sat.sc", 32'(sc_o[0]), 32'hFFFF);
        cyc(1, 0, 0, IA);
        chk("sat.hold", 32'(sc_o[0]), 32'hFFFF);
        chk("sat.fe", 32'(fe_o[0]), 32'h0);
        chk_all("sat");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
